mem_req_queue: RTL and testbench

- Request front-end that sits directly upstream of the mem_example DDR2 wrapper, in the clk_cpu domain.
- Accepts read and write requests from a client over a valid/ready interface and buffers them in a small FIFO.
- Issues requests one at a time to the memory wrapper using its strobe / ready / transaction_complete handshake.
- Returns one response per request, in order, with a timeout guard. It replaces the ad-hoc traffic-generator FSM as the standard way to talk to RAM.

---
 rtl/mem_req_queue.sv | 171 +++++++++++++++++
 tb/tb_mem_req_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: request FIFO feeding a single-outstanding issue FSM in front of the DDR2 wrapper.
// Responses return in request order; a per-request timeout aborts transactions that never complete.
//   state   | meaning
//   S_IDLE  | pop FIFO head onto mem_* when non-empty
//   S_ISSUE | wait for mem_ready, then strobe for one cycle
//   S_WAIT  | count cycles until transaction_complete or timeout
//   S_RESP  | hold response until client accepts
module mem_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096,
    parameter int ADDR_W  = 28
) (
    input  logic              clk_cpu,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_width,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_width,
    output logic [63:0]       mem_d_to_ram,
    output logic              mem_wstrobe,
    output logic              mem_rstrobe,
    input  logic              mem_ready,
    input  logic              mem_transaction_complete,
    input  logic [63:0]       mem_d_from_ram,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_q_addr  [DEPTH];
    logic [1:0]          r_q_width [DEPTH];
    logic [63:0]         r_q_wdata [DEPTH];
    logic                r_q_write [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [1:0]          r_mem_width;
    logic [63:0]         r_mem_wdata;
    logic                r_mem_write;
    logic [TMR_W-1:0]    r_tmr;
    logic [63:0]         r_rsp_rdata;
    logic                r_rsp_timeout;
    logic [7:0]          r_err_count;
    logic                w_full, w_empty, w_push, w_pop;
    logic                w_strobe, w_done, w_tmo;
    logic [TMR_W-1:0]    w_tmr_nxt;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_tmr_nxt = r_tmr + TMR_W'(1);

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_cpu) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= req_addr;
            r_q_width[r_wr_ptr] <= req_width;
            r_q_wdata[r_wr_ptr] <= req_wdata;
            r_q_write[r_wr_ptr] <= req_write;
        end
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    w_strobe    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority when it lands on the timeout boundary.
                if (mem_transaction_complete) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_tmr_nxt == TMR_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr    <= '0;
            r_mem_width   <= '0;
            r_mem_wdata   <= '0;
            r_mem_write   <= 1'b0;
            r_tmr         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_err_count   <= '0;
        end else begin
            if (w_pop) begin
                r_mem_addr  <= r_q_addr[r_rd_ptr];
                r_mem_width <= r_q_width[r_rd_ptr];
                r_mem_wdata <= r_q_wdata[r_rd_ptr];
                r_mem_write <= r_q_write[r_rd_ptr];
            end
            if (w_strobe)              r_tmr <= '0;
            else if (r_state == S_WAIT) r_tmr <= w_tmr_nxt;
            if (w_done) begin
                r_rsp_rdata   <= r_mem_write ? 64'd0 : mem_d_from_ram;
                r_rsp_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b1;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign req_ready    = !w_full;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_write    = r_mem_write;
    assign rsp_timeout  = r_rsp_timeout;
    assign mem_addr     = r_mem_addr;
    assign mem_width    = r_mem_width;
    assign mem_d_to_ram = r_mem_wdata;
    assign mem_wstrobe  = w_strobe && r_mem_write;
    assign mem_rstrobe  = w_strobe && !r_mem_write;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: wrapper responder, transaction-level scoreboard and directed scenarios.
module tb_mem_req_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 28;
    localparam logic [1:0] W8 = 2'd0, W16 = 2'd1, W32 = 2'd2, W64 = 2'd3;

    logic              clk_cpu = 1'b0;
    logic              rst_n   = 1'b0;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [1:0]        req_width = '0;
    logic [63:0]       req_wdata = '0;
    logic              rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_timeout;
    logic [63:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_width;
    logic [63:0]       mem_d_to_ram;
    logic              mem_wstrobe, mem_rstrobe;
    logic              mem_ready = 1'b1;
    logic              mem_transaction_complete;
    logic [63:0]       mem_d_from_ram;
    logic              busy;
    logic [7:0]        err_count;

    mem_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk_cpu(clk_cpu), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_d_to_ram(mem_d_to_ram),
        .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe), .mem_ready(mem_ready),
        .mem_transaction_complete(mem_transaction_complete),
        .mem_d_from_ram(mem_d_from_ram), .busy(busy), .err_count(err_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    int cyc = 0;
    always @(posedge clk_cpu) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        width;
        logic [63:0]       wdata;
    } req_t;

    req_t        exp_q[$];
    logic [63:0] mem_model [logic [ADDR_W-1:0]];
    int          cfg_delay = 10;
    int          inject_req = 0;
    logic [63:0] rd_for_resp = '0;

    bit          out_act = 0;
    bit          rsp_seen = 0;
    req_t        out_req;
    logic [63:0] out_rdata;
    bit          out_tmo;
    int          out_lat;
    int          strobe_cyc = 0;
    int          n_acc = 0, n_rsp = 0, n_strobes = 0, err_model = 0;
    int          last_strobe_cyc = 0;
    logic [ADDR_W-1:0] last_strobe_addr = '0;
    logic        last_strobe_w = 1'b0;

    // Wrapper model: completes cfg_delay cycles after a strobe (0 = never).
    initial begin
        int cd = -1;
        int inject_seen = 0;
        mem_transaction_complete = 1'b0;
        mem_d_from_ram = '0;
        forever begin
            @(negedge clk_cpu);
            mem_transaction_complete = 1'b0;
            mem_d_from_ram = {32'hDEAD_BEEF, 32'(cyc)};
            if (!rst_n) cd = -1;
            else if (mem_wstrobe || mem_rstrobe) cd = (cfg_delay == 0) ? -1 : cfg_delay;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_transaction_complete = 1'b1;
                    mem_d_from_ram = rd_for_resp;
                    cd = -1;
                end
            end
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                mem_transaction_complete = 1'b1;
            end
        end
    end

    // Scoreboard: in-order requests, one outstanding, response content and latency.
    initial begin
        forever begin
            @(negedge clk_cpu);
            if (!rst_n) begin
                exp_q.delete();
                out_act = 0; n_acc = 0; n_rsp = 0; err_model = 0;
                continue;
            end
            chk("busy", busy, 64'(n_acc != n_rsp));
            if (n_acc - n_rsp < DEPTH) chk("req_ready_room", req_ready, 1);
            if (n_acc - n_rsp > DEPTH) chk("req_ready_full", req_ready, 0);
            if (mem_wstrobe || mem_rstrobe) begin
                n_strobes++;
                last_strobe_cyc  = cyc;
                last_strobe_addr = mem_addr;
                last_strobe_w    = mem_wstrobe;
                chk("strobe_needs_mem_ready", mem_ready, 1);
                chk("strobe_exclusive", mem_wstrobe && mem_rstrobe, 0);
                chk("strobe_one_outstanding", out_act, 0);
                if (exp_q.size() == 0) chk("strobe_unexpected", 1, 0);
                else begin
                    out_req = exp_q.pop_front();
                    chk("strobe_kind", mem_wstrobe, out_req.write);
                    chk("strobe_addr", mem_addr, out_req.addr);
                    chk("strobe_width", mem_width, out_req.width);
                    chk("strobe_wdata", mem_d_to_ram, out_req.wdata);
                    out_tmo = (cfg_delay == 0) || (cfg_delay >= TIMEOUT);
                    out_lat = out_tmo ? TIMEOUT : cfg_delay + 1;
                    if (out_req.write) begin
                        out_rdata   = '0;
                        rd_for_resp = 64'h5555_AAAA_5555_AAAA;
                        if (!out_tmo) mem_model[out_req.addr] = out_req.wdata;
                    end else begin
                        rd_for_resp = mem_model.exists(out_req.addr) ? mem_model[out_req.addr] : 64'd0;
                        out_rdata   = out_tmo ? 64'd0 : rd_for_resp;
                    end
                    out_act = 1; rsp_seen = 0; strobe_cyc = cyc;
                end
            end else if (out_act) begin
                chk("hold_addr", mem_addr, out_req.addr);
                chk("hold_width", mem_width, out_req.width);
                chk("hold_wdata", mem_d_to_ram, out_req.wdata);
                if (rsp_valid) begin
                    if (!rsp_seen) begin
                        chk("rsp_latency", 64'(cyc - strobe_cyc), 64'(out_lat));
                        rsp_seen = 1;
                        if (out_tmo && err_model < 255) err_model++;
                    end
                    chk("rsp_write", rsp_write, out_req.write);
                    chk("rsp_rdata", rsp_rdata, out_rdata);
                    chk("rsp_timeout", rsp_timeout, out_tmo);
                    if (rsp_ready) begin out_act = 0; n_rsp++; end
                end
            end else chk("rsp_valid_idle", rsp_valid, 0);
            chk("err_count", err_count, 64'(err_model));
            if (req_valid && req_ready) begin
                exp_q.push_back('{req_write, req_addr, req_width, req_wdata});
                n_acc++;
            end
        end
    end

    task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [1:0] wd, input logic [63:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_width = wd; req_wdata = d;
        @(negedge clk_cpu);
        while (!req_ready && n < 200) begin @(negedge clk_cpu); n++; end
        if (!req_ready) chk("push_accept_timeout", 0, 1);
        @(posedge clk_cpu); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output logic [63:0] d, output logic w, output logic t, output int c);
        int n = 0;
        @(negedge clk_cpu);
        while (!rsp_valid && n < limit) begin @(negedge clk_cpu); n++; end
        chk("rsp_arrives", rsp_valid, 1);
        d = rsp_rdata; w = rsp_write; t = rsp_timeout; c = cyc;
        @(posedge clk_cpu); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        w, t;
        int          c, p, s, n;
        repeat (3) @(posedge clk_cpu);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_strobes", {mem_wstrobe, mem_rstrobe}, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(posedge clk_cpu); #1;

        // 1: 64-bit write, completes 10 cycles after strobe
        cfg_delay = 10; p = cyc;
        push(1'b1, 28'd28, W64, 64'hA000_0000_0000_0000);
        wait_rsp(100, d, w, t, c);
        chk("t1_push_to_strobe", 64'(last_strobe_cyc - p), 2);
        chk("t1_strobe_addr", last_strobe_addr, 28);
        chk("t1_wstrobe", last_strobe_w, 1);
        chk("t1_rsp_latency", 64'(c - last_strobe_cyc), 11);
        chk("t1_rsp_write", w, 1);
        chk("t1_rsp_rdata", d, 0);
        chk("t1_rsp_timeout", t, 0);

        // 2: 16-bit read back
        cfg_delay = 4;
        push(1'b0, 28'd28, W16, 64'd0);
        wait_rsp(100, d, w, t, c);
        chk("t2_rdata_hi", d[63:48], 16'hA000);
        chk("t2_rsp_write", w, 0);
        chk("t2_rsp_timeout", t, 0);

        // 3: back-pressure with the wrapper busy
        mem_ready = 1'b0; cfg_delay = 2; s = n_strobes;
        push(1'b1, 28'h100, W64, 64'h1111_2222_3333_4444);
        push(1'b0, 28'h100, W64, 64'd0);
        push(1'b1, 28'h104, W32, 64'h5555_6666_0000_0000);
        push(1'b0, 28'h104, W32, 64'd0);
        push(1'b0, 28'h108, W8,  64'd0);
        chk("t3_req_ready_low", req_ready, 0);
        chk("t3_no_strobe_yet", 64'(n_strobes - s), 0);
        mem_ready = 1'b1;
        wait_rsp(100, d, w, t, c); chk("t3_r1", {w, d}, {1'b1, 64'd0});
        wait_rsp(100, d, w, t, c); chk("t3_r2", {w, d}, {1'b0, 64'h1111_2222_3333_4444});
        wait_rsp(100, d, w, t, c); chk("t3_r3", {w, d}, {1'b1, 64'd0});
        wait_rsp(100, d, w, t, c); chk("t3_r4", {w, d}, {1'b0, 64'h5555_6666_0000_0000});
        wait_rsp(100, d, w, t, c); chk("t3_r5", {w, d}, {1'b0, 64'd0});
        chk("t3_strobe_count", 64'(n_strobes - s), 5);

        // 4: timeout, late completion, and the boundary either side
        cfg_delay = 0;
        push(1'b0, 28'd200, W64, 64'd0);
        wait_rsp(100, d, w, t, c);
        chk("t4_timeout", t, 1);
        chk("t4_timeout_latency", 64'(c - last_strobe_cyc), 16);
        chk("t4_timeout_rdata", d, 0);
        chk("t4_err_count", err_count, 1);
        inject_req++;
        repeat (4) @(posedge clk_cpu);
        #1;
        chk("t4_late_ignored", {rsp_valid, busy}, 0);
        cfg_delay = 15;
        push(1'b1, 28'd204, W64, 64'hBEEF_0000_0000_0001);
        wait_rsp(100, d, w, t, c);
        chk("t4_edge_complete_wins", t, 0);
        chk("t4_edge_latency", 64'(c - last_strobe_cyc), 16);
        cfg_delay = 16;
        push(1'b0, 28'd204, W64, 64'd0);
        wait_rsp(100, d, w, t, c);
        chk("t4_past_edge_timeout", t, 1);
        chk("t4_err_count_2", err_count, 2);
        cfg_delay = 3;
        push(1'b0, 28'd204, W64, 64'd0);
        wait_rsp(100, d, w, t, c);
        chk("t4_recovered", {t, d}, {1'b0, 64'hBEEF_0000_0000_0001});

        // 5: response stall holds everything
        cfg_delay = 2; rsp_ready = 1'b0;
        push(1'b0, 28'd28, W64, 64'd0);
        push(1'b1, 28'd300, W8, 64'h7700_0000_0000_0000);
        n = 0;
        @(negedge clk_cpu);
        while (!rsp_valid && n < 50) begin @(negedge clk_cpu); n++; end
        chk("t5_rsp_arrives", rsp_valid, 1);
        s = n_strobes;
        repeat (20) @(negedge clk_cpu);
        chk("t5_stall_valid", rsp_valid, 1);
        chk("t5_stall_rdata", rsp_rdata, 64'hA000_0000_0000_0000);
        chk("t5_stall_no_strobe", 64'(n_strobes - s), 0);
        @(posedge clk_cpu); #1;
        rsp_ready = 1'b1;
        @(posedge clk_cpu); #1;
        wait_rsp(100, d, w, t, c);
        chk("t5_next_write", {w, t, d}, {1'b1, 1'b0, 64'd0});
        chk("t5_next_issued", 64'(n_strobes - s), 1);

        // 6: reset while one request waits and three are queued
        cfg_delay = 0;
        push(1'b0, 28'd500, W64, 64'd0);
        push(1'b0, 28'd504, W64, 64'd0);
        push(1'b0, 28'd508, W64, 64'd0);
        push(1'b0, 28'd512, W64, 64'd0);
        repeat (2) @(posedge clk_cpu);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_req_ready", req_ready, 1);
        chk("t6_rsp", {rsp_valid, rsp_write, rsp_timeout}, 0);
        chk("t6_rsp_rdata", rsp_rdata, 0);
        chk("t6_strobes", {mem_wstrobe, mem_rstrobe}, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err_count", err_count, 0);
        chk("t6_mem_out", {mem_addr, mem_width, mem_d_to_ram}, 0);
        repeat (2) @(posedge clk_cpu);
        #1;
        rst_n = 1'b1; cfg_delay = 2; s = n_strobes;
        repeat (20) @(posedge clk_cpu);
        #1;
        chk("t6_no_strobe_after_reset", 64'(n_strobes - s), 0);
        chk("t6_idle_after_reset", busy, 0);
        push(1'b1, 28'd400, W32, 64'h1234_5678_0000_0000);
        wait_rsp(100, d, w, t, c);
        chk("t6_post_reset_request", {w, t}, {1'b1, 1'b0});

        repeat (3) @(posedge clk_cpu);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
